// File: rtl/debounce_bank.sv
// Multi-channel debouncer: 2-flop sync + tick-gated stability counter; new level accepted after THRESH ticked edges of disagreement.
// Latency THRESH+2 edges from sampling with TICK=1; no backpressure, all outputs are registered levels/one-cycle pulses.
module debounce_bank #(
  parameter int   WIDTH     = 8,
  parameter int   THRESH    = 1000,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic             C,
  input  logic             RN,
  input  logic             TICK,
  input  logic [WIDTH-1:0] I,
  output logic [WIDTH-1:0] O,
  output logic [WIDTH-1:0] RISE,
  output logic [WIDTH-1:0] FALL,
  output logic             CHG
);

  localparam int CW = $clog2(THRESH + 1);
  localparam logic [CW-1:0] LAST = CW'(THRESH - 1);

  logic [WIDTH-1:0]         s1;
  logic [WIDTH-1:0]         s2;
  logic [WIDTH-1:0]         o_nxt;
  logic [WIDTH-1:0]         rise_nxt;
  logic [WIDTH-1:0]         fall_nxt;
  logic [WIDTH-1:0][CW-1:0] cnt;
  logic [WIDTH-1:0][CW-1:0] cnt_nxt;

  // Counter only runs while the synchronised input disagrees with the accepted level.
  always_comb begin
    o_nxt    = O;
    cnt_nxt  = cnt;
    rise_nxt = '0;
    fall_nxt = '0;
    for (int k = 0; k < WIDTH; k++) begin
      if (s2[k] == O[k]) begin
        cnt_nxt[k] = '0;
      end else if (TICK) begin
        if (cnt[k] == LAST) begin
          o_nxt[k]    = s2[k];
          cnt_nxt[k]  = '0;
          rise_nxt[k] = s2[k];
          fall_nxt[k] = ~s2[k];
        end else begin
          cnt_nxt[k] = cnt[k] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge C or negedge RN) begin
    if (!RN) begin
      s1   <= {WIDTH{RESET_VAL}};
      s2   <= {WIDTH{RESET_VAL}};
      O    <= {WIDTH{RESET_VAL}};
      cnt  <= '0;
      RISE <= '0;
      FALL <= '0;
      CHG  <= 1'b0;
    end else begin
      s1   <= I;
      s2   <= s1;
      O    <= o_nxt;
      cnt  <= cnt_nxt;
      RISE <= rise_nxt;
      FALL <= fall_nxt;
      CHG  <= |(rise_nxt | fall_nxt);
    end
  end

endmodule

// File: tb/tb_debounce_bank.sv
// Bench for debounce_bank: three instances (THRESH 4/3/2, RESET_VAL 0/1/0) checked each cycle against a
// behavioural run-length model, plus hand-computed literal expectations for the directed scenarios.
module tb_debounce_bank;

  localparam int TH [3] = '{4, 3, 2};
  localparam bit [2:0] RVS = 3'b010;

  logic       C = 1'b0;
  logic       RN = 1'b0;
  logic [7:0] iv [3];
  logic       tk [3];
  wire  [7:0] d_o [3];
  wire  [7:0] d_r [3];
  wire  [7:0] d_f [3];
  wire        d_c [3];

  int total = 0;
  int bad = 0;
  logic cmp_en = 1'b0;
  logic watch = 1'b0;
  logic seen = 1'b0;

  always #5 C = ~C;

  debounce_bank #(.WIDTH(8), .THRESH(4), .RESET_VAL(1'b0)) u0 (
    .C(C), .RN(RN), .TICK(tk[0]), .I(iv[0]),
    .O(d_o[0]), .RISE(d_r[0]), .FALL(d_f[0]), .CHG(d_c[0]));
  debounce_bank #(.WIDTH(8), .THRESH(3), .RESET_VAL(1'b1)) u1 (
    .C(C), .RN(RN), .TICK(tk[1]), .I(iv[1]),
    .O(d_o[1]), .RISE(d_r[1]), .FALL(d_f[1]), .CHG(d_c[1]));
  debounce_bank #(.WIDTH(8), .THRESH(2), .RESET_VAL(1'b0)) u2 (
    .C(C), .RN(RN), .TICK(tk[2]), .I(iv[2]),
    .O(d_o[2]), .RISE(d_r[2]), .FALL(d_f[2]), .CHG(d_c[2]));

  // Model: raw input delayed two edges, and per channel the number of ticked
  // edges in a row on which that delayed value differed from the output.
  logic [7:0] m_d1 [3];
  logic [7:0] m_d2 [3];
  logic [7:0] m_o [3];
  logic [7:0] m_r [3];
  logic [7:0] m_f [3];
  logic       m_c [3];
  int         run [3][8];
  logic [7:0] prev;

  always @(posedge C or negedge RN) begin
    for (int n = 0; n < 3; n++) begin
      if (!RN) begin
        m_d1[n] = {8{RVS[n]}};
        m_d2[n] = {8{RVS[n]}};
        m_o[n]  = {8{RVS[n]}};
        m_r[n]  = 8'h00;
        m_f[n]  = 8'h00;
        m_c[n]  = 1'b0;
        for (int k = 0; k < 8; k++) run[n][k] = 0;
      end else begin
        prev = m_o[n];
        for (int k = 0; k < 8; k++) begin
          if (m_d2[n][k] == prev[k]) run[n][k] = 0;
          else if (tk[n]) begin
            run[n][k] = run[n][k] + 1;
            if (run[n][k] == TH[n]) begin
              m_o[n][k] = m_d2[n][k];
              run[n][k] = 0;
            end
          end
        end
        m_r[n] = m_o[n] & ~prev;
        m_f[n] = prev & ~m_o[n];
        m_c[n] = (m_r[n] | m_f[n]) != 8'h00;
        m_d2[n] = m_d1[n];
        m_d1[n] = iv[n];
      end
    end
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge C) begin
    if (cmp_en) begin
      for (int n = 0; n < 3; n++) begin
        chk($sformatf("model_o%0d", n), d_o[n], m_o[n]);
        chk($sformatf("model_rise%0d", n), d_r[n], m_r[n]);
        chk($sformatf("model_fall%0d", n), d_f[n], m_f[n]);
        chk($sformatf("model_chg%0d", n), {7'd0, d_c[n]}, {7'd0, m_c[n]});
      end
    end
    if (watch && (d_r[0][3] || d_f[0][3] || d_c[0])) seen = 1'b1;
  end

  task automatic step(input int n);
    repeat (n) @(posedge C);
    #2;
  endtask

  initial begin
    iv[0] = 8'h00; iv[1] = 8'hFF; iv[2] = 8'h00;
    tk[0] = 1'b1;  tk[1] = 1'b0;  tk[2] = 1'b1;

    // Reset state while RN held low.
    step(1);
    chk("rst_o0", d_o[0], 8'h00);
    chk("rst_rise0", d_r[0], 8'h00);
    chk("rst_fall0", d_f[0], 8'h00);
    chk("rst_chg0", {7'd0, d_c[0]}, 8'h00);
    chk("rst_o1", d_o[1], 8'hFF);
    RN = 1'b1;
    cmp_en = 1'b1;
    step(2);

    // Clean rise on channel 0, THRESH=4: new level after edge 5.
    iv[0] = 8'h01;
    step(5);
    chk("rise_pre_o0", d_o[0], 8'h00);
    step(1);
    chk("rise_o0", d_o[0], 8'h01);
    chk("rise_rise0", d_r[0], 8'h01);
    chk("rise_chg0", {7'd0, d_c[0]}, 8'h01);
    chk("rise_fall0", d_f[0], 8'h00);
    step(1);
    chk("rise_end_rise0", d_r[0], 8'h00);
    chk("rise_end_chg0", {7'd0, d_c[0]}, 8'h00);

    // Bounce on channel 3: 3 high, 1 low, 3 high, then low.
    watch = 1'b1;
    iv[0] = 8'h09; step(3);
    iv[0] = 8'h01; step(1);
    iv[0] = 8'h09; step(3);
    iv[0] = 8'h01; step(6);
    watch = 1'b0;
    chk("bounce_o0", d_o[0], 8'h01);
    chk("bounce_pulse", {7'd0, seen}, 8'h00);

    // Reset after 3 counted ticks on channel 2 (one tick short of acceptance).
    iv[0] = 8'h05;
    step(5);
    chk("mid_pre_o0", d_o[0], 8'h01);
    RN = 1'b0;
    #1;
    chk("mid_rst_o0", d_o[0], 8'h00);
    chk("mid_rst_rise0", d_r[0], 8'h00);
    #1;
    RN = 1'b1;
    step(1);
    chk("mid_first_rise0", d_r[0], 8'h00);
    step(4);
    chk("mid_pre_acc_o0", d_o[0], 8'h00);
    step(1);
    chk("mid_acc_o0", d_o[0], 8'h05);
    chk("mid_acc_rise0", d_r[0], 8'h05);
    chk("mid_acc_chg0", {7'd0, d_c[0]}, 8'h01);
    step(1);
    chk("mid_end_rise0", d_r[0], 8'h00);

    // Tick gating on instance 1 (THRESH=3, RESET_VAL=1): ticks on edges 3, 7, 11.
    iv[1] = 8'hFD;
    for (int e = 0; e < 14; e++) begin
      tk[1] = (e % 4 == 3);
      step(1);
      if (e == 10) begin
        chk("tick_pre_o1", d_o[1], 8'hFF);
        chk("tick_pre_fall1", d_f[1], 8'h00);
      end
      if (e == 11) begin
        chk("tick_o1", d_o[1], 8'hFD);
        chk("tick_fall1", d_f[1], 8'h02);
        chk("tick_chg1", {7'd0, d_c[1]}, 8'h01);
      end
      if (e == 12) chk("tick_end_fall1", d_f[1], 8'h00);
    end
    tk[1] = 1'b0;

    // Simultaneous channels on instance 2 (THRESH=2): accept after edge 3.
    iv[2] = 8'hA5;
    step(3);
    chk("sim_pre_o2", d_o[2], 8'h00);
    step(1);
    chk("sim_o2", d_o[2], 8'hA5);
    chk("sim_rise2", d_r[2], 8'hA5);
    chk("sim_fall2", d_f[2], 8'h00);
    chk("sim_chg2", {7'd0, d_c[2]}, 8'h01);
    step(1);
    chk("sim_end_rise2", d_r[2], 8'h00);
    chk("sim_end_chg2", {7'd0, d_c[2]}, 8'h00);
    iv[2] = 8'h00;
    step(4);
    chk("sim_fall_o2", d_o[2], 8'h00);
    chk("sim_fall_fall2", d_f[2], 8'hA5);
    chk("sim_fall_rise2", d_r[2], 8'h00);
    step(3);

    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/debounce_bank.md
# debounce_bank

Parametrised multi-channel switch/button debouncer for the board-input front end; it replaces per-pin fixed shift-register debouncers with one block. Each channel passes through a two-flop synchroniser and a saturating-threshold stability counter, and produces a clean level plus registered one-cycle rise/fall pulses. A shared tick input scales the debounce period without widening counters, so one prescaler can drive every bank in the design.

## Interface
- WIDTH, 8, number of independent channels (≥1)
- THRESH, 1000, consecutive ticks of disagreement needed to accept a new level (≥1); counter width CW = clog2(THRESH+1)
- RESET_VAL, 1'b0, level loaded into synchroniser and output flops on reset (applies to all channels)
- C  input  1  clock; all state on rising edge
- RN  input  1  reset, asynchronous assert, active-low
- TICK  input  1  count enable; counters advance only on edges where TICK=1
- I  input  WIDTH  raw asynchronous inputs
- O  output  WIDTH  debounced level, registered
- RISE  output  WIDTH  one-cycle pulse per channel on accepted 0→1
- FALL  output  WIDTH  one-cycle pulse per channel on accepted 1→0
- CHG  output  1  OR of all RISE and FALL bits, registered in the same cycle

## Operation
- Reset (RN=0): S1, S2, O ← {WIDTH{RESET_VAL}}; all counters ← 0; RISE, FALL, CHG ← 0. Takes effect immediately, with no clock needed.
- Synchroniser per channel: S1 ← I, S2 ← S1.
- Per-channel state machine, implicit in the O/cnt pair. It has two states:
  - STABLE: S2==O. cnt ← 0 on every edge, regardless of TICK.
  - PENDING: S2!=O.
    - TICK=0: cnt holds.
    - TICK=1 and cnt < THRESH-1: cnt ← cnt+1.
    - TICK=1 and cnt == THRESH-1: O ← S2, cnt ← 0, and RISE or FALL is set for one cycle.
- Any single edge with S2==O during PENDING clears cnt. Bounces shorter than THRESH ticks are therefore rejected completely.
- RISE[k]/FALL[k] are 1 only in the cycle immediately after O[k] changes, i.e. they are valid together with the new O. They are 0 otherwise.
- CHG = |(RISE|FALL), driven from the same register stage (computed from the next-state values) so it aligns with RISE/FALL.
- Channels are fully independent. Simultaneous acceptance on several channels raises all corresponding pulse bits in the same cycle.
- Counter never exceeds THRESH-1, so there is no wrap-around. With THRESH=1, a level is accepted on the first ticked edge of disagreement.

## Timing
- Latency with TICK held 1: I changes before edge 0; S1 captures at edge 0 and S2 at edge 1.
  - First count at edge 2; O and pulse update at edge THRESH+1.
  - Total THRESH+2 edges from the sampling edge to the new O.
- With TICK duty-cycled, latency is 2 edges plus THRESH ticked edges seen while PENDING.
- Pulses are exactly 1 clock wide, independent of TICK width.
- Reset released mid-count: counters restart from 0, O = RESET_VAL, and no pulse is emitted on the first edge after release.
- If I returns to O's value on the same edge that cnt reaches THRESH-1, the accept decision uses S2. A late change is therefore seen 2 edges later, and acceptance still occurs if S2 is still in disagreement at that edge.
- All outputs come directly from flops; there are no combinational paths from I or TICK to outputs.

## Test plan
- Reset: WIDTH=8, RESET_VAL=0, RN pulsed low between clock edges → O=8'h00, RISE=FALL=0, CHG=0 immediately, with no clock edge needed.
- Clean rise: THRESH=4, TICK=1, I[0] 0→1 held → O[0]=1 and RISE[0]=1 after edge 5 (sampling edge 0), RISE[0]=0 after edge 6, CHG mirrors RISE, FALL stays 0.
- Bounce rejection: THRESH=4, I[3] high for 3 cycles, low 1, high 3, then low → O[3] stays 0, and RISE/FALL/CHG never assert.
- Tick gating: THRESH=3, TICK high every 4th cycle, I[1] 1→0 with RESET_VAL=1 → FALL[1] pulses one clock wide after the 3rd ticked edge in PENDING (edge 2 + 3 ticks). Cycles without a tick do not advance the counter.
- Simultaneous channels: THRESH=2, I 8'h00→8'hA5 in one cycle → after edge 3, O=8'hA5, RISE=8'hA5, FALL=0, CHG=1 for exactly one cycle. Then I→8'h00 → FALL=8'hA5.
- Reset mid-operation: THRESH=8, I[2] rises, RN pulsed low after 5 counted ticks, I[2] kept high → O[2]=0 immediately. After release, O[2] rises exactly THRESH+2 edges after the first post-release edge, with a single RISE pulse.
